hidden_wires_reader: RTL

HIDDEN_WIRES_READER -- requirements
Module: hidden_wires_reader

---
 rtl/hidden_wires_pkg.sv | 32 +++
 rtl/hw_sync_fifo.sv | 64 ++++++
 rtl/hidden_wires_reader.sv | 81 ++++++++
 3 files changed

// File: rtl/hidden_wires_pkg.sv
// Shared hidden-wire bus, reader FIFO entry type and defaults.
// hw_entry_t carries a timestamp when HIDDEN_WIRES_TIMESTAMP_EN is defined.
package hidden_wires_pkg;

  localparam int HW_READER_DEPTH_DEFAULT = 8;

  typedef struct packed {
    logic [63:0] address;
    logic [31:0] data;
    logic        enable;
  } hidden_wires_t;

  typedef struct packed {
    logic [63:0] address;
    logic [31:0] data;
`ifdef HIDDEN_WIRES_TIMESTAMP_EN
    logic [31:0] timestamp;
`endif
  } hw_entry_t;

  // The shared bus; only the writer ever stores into it.
  hidden_wires_t hw_bus;

  function automatic hidden_wires_t connect(
    input logic          set,
    input hidden_wires_t cur,
    input hidden_wires_t val
  );
    return set ? val : cur;
  endfunction

endpackage

// File: rtl/hw_sync_fifo.sv
// Synchronous FIFO of hw_entry_t with clear, pop-when-full push and drop flag.
// Head reads as zero while empty.
module hw_sync_fifo
  import hidden_wires_pkg::*;
#(
  parameter int DEPTH = HW_READER_DEPTH_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_clear,
  input  logic                   i_push,
  input  hw_entry_t              i_data,
  input  logic                   i_pop,
  output hw_entry_t              o_head,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_empty,
  output logic                   o_drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  hw_entry_t     r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          w_full;
  logic          w_rd;
  logic          w_wr;

  assign o_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_rd    = i_pop && !o_empty && !i_clear;
  assign w_wr    = i_push && !i_clear && (!w_full || w_rd);
  assign o_drop  = i_push && !i_clear && w_full && !w_rd;
  assign o_head  = o_empty ? '0 : r_mem[r_rptr];
  assign o_count = r_count;

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr] <= i_data;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_clear) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + AW'(1);
      if (w_rd) r_rptr <= r_rptr + AW'(1);
      unique case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/hidden_wires_reader.sv
// Samples the shared hidden-wire bus each edge and queues enabled transactions.
// HIDDEN_WIRES_TIMESTAMP_EN adds a per-entry cycle timestamp output.
module hidden_wires_reader
  import hidden_wires_pkg::*;
#(
  parameter int DEPTH = HW_READER_DEPTH_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [63:0]            out_address,
  output logic [31:0]            out_data,
`ifdef HIDDEN_WIRES_TIMESTAMP_EN
  output logic [31:0]            out_timestamp,
`endif
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
);

  hidden_wires_t w_hw;
  hw_entry_t     w_in;
  hw_entry_t     w_head;
  logic          w_empty;
  logic          w_pop;
  logic          w_drop;
  logic          r_overflow;

`ifdef HIDDEN_WIRES_TIMESTAMP_EN
  logic [31:0]   r_cycle;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_cycle <= '0;
    else        r_cycle <= r_cycle + 32'd1;
  end
`endif

  always_comb w_hw = connect(1'b0, hw_bus, '0);

  always_comb begin
    w_in         = '0;
    w_in.address = w_hw.address;
    w_in.data    = w_hw.data;
`ifdef HIDDEN_WIRES_TIMESTAMP_EN
    w_in.timestamp = r_cycle;
`endif
  end

  assign out_valid = !w_empty;
  assign w_pop     = out_valid && out_ready;

  hw_sync_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (clear),
    .i_push  (w_hw.enable),
    .i_data  (w_in),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_count (count),
    .o_empty (w_empty),
    .o_drop  (w_drop)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_overflow <= 1'b0;
    else if (clear)  r_overflow <= 1'b0;
    else if (w_drop) r_overflow <= 1'b1;
  end

  assign overflow    = r_overflow;
  assign out_address = w_head.address;
  assign out_data    = w_head.data;
`ifdef HIDDEN_WIRES_TIMESTAMP_EN
  assign out_timestamp = w_head.timestamp;
`endif

endmodule
